// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - start/busy/done handshake and HI/LO bus of mult_div_unit
// MTHI/MTLO write port exists only when HILO_WRITE_EN is defined.
interface mult_div_unit_if #(parameter int WIDTH = 32) ();
  logic             start_i;
  logic [1:0]       op_i;
  logic [WIDTH-1:0] operand_a_i;
  logic [WIDTH-1:0] operand_b_i;
  logic             busy_o;
  logic             done_o;
  logic             div_zero_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
`ifdef HILO_WRITE_EN
  logic             hi_write_i;
  logic             lo_write_i;
  logic [WIDTH-1:0] write_data_i;
`endif

  modport master (
    output start_i, op_i, operand_a_i, operand_b_i,
`ifdef HILO_WRITE_EN
    output hi_write_i, lo_write_i, write_data_i,
`endif
    input  busy_o, done_o, div_zero_o, hi_o, lo_o
  );

  modport slave (
    input  start_i, op_i, operand_a_i, operand_b_i,
`ifdef HILO_WRITE_EN
    input  hi_write_i, lo_write_i, write_data_i,
`endif
    output busy_o, done_o, div_zero_o, hi_o, lo_o
  );
endinterface

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers
// Optional macro HILO_WRITE_EN adds MTHI/MTLO writes while idle.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mult_div_unit_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_FIX, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               dz_q, dz_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               is_div, idle_like;
  logic               a_sgn, b_sgn;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH+1:0]   div_trial, div_diff;
  logic               div_neg;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  assign is_div    = op_q[1];
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  assign a_sgn     = ~op_q[0] & a_q[WIDTH-1];
  assign b_sgn     = ~op_q[0] & b_q[WIDTH-1];
  assign a_mag     = a_sgn ? -a_q : a_q;
  assign b_mag     = b_sgn ? -b_q : b_q;

  // Multiply: acc holds {partial product, remaining multiplier bits}.
  assign mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);

  // Divide: acc[WIDTH-1:0] shifts dividend bits out the top and quotient bits in the bottom.
  assign div_trial = {rem_q, acc_q[WIDTH-1]};
  assign div_diff  = div_trial - {2'b00, b_q};
  assign div_neg   = div_diff[WIDTH+1];

  assign prod_fix  = neg_q ? -acc_q : acc_q;
  assign quo_fix   = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix   = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start_i) begin
          state_d = S_LOAD;
          op_d    = bus.op_i;
          a_d     = bus.operand_a_i;
          b_d     = bus.operand_b_i;
          dz_d    = 1'b0;
        end
      end
      S_LOAD: begin
        a_d    = a_mag;
        b_d    = b_mag;
        neg_d  = a_sgn ^ b_sgn;
        rneg_d = a_sgn;
        cnt_d  = '0;
        rem_d  = '0;
        acc_d  = {{WIDTH{1'b0}}, (is_div ? a_mag : b_mag)};
        if (is_div && (b_q == '0)) begin
          dz_d    = 1'b1;
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (is_div) begin
          rem_d = div_neg ? div_trial[WIDTH:0] : div_diff[WIDTH:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], ~div_neg};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        if (is_div) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

`ifdef HILO_WRITE_EN
    if (idle_like && bus.hi_write_i) hi_d = bus.write_data_i;
    if (idle_like && bus.lo_write_i) lo_d = bus.write_data_i;
`endif
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign bus.busy_o     = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_FIX);
  assign bus.done_o     = (state_q == S_DONE);
  assign bus.div_zero_o = (state_q == S_DONE) && dz_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - self-checking bench for mult_div_unit (WIDTH 32 and 8)
module tb_mult_div_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) b32();
  mult_div_unit_if #(.WIDTH(8))  b8();

  mult_div_unit #(.WIDTH(32)) u_dut32 (.clk_i(clk), .rst_i(rst), .bus(b32));
  mult_div_unit #(.WIDTH(8))  u_dut8  (.clk_i(clk), .rst_i(rst), .bus(b8));

  int checks = 0;
  int errors = 0;
  logic [63:0] mhi = '0, mlo = '0;

  typedef struct packed {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;
  vec_t vecs[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic on w-bit operands (w <= 32).
  function automatic void model(input int w, input logic [1:0] op, input logic [63:0] a, b,
                                input logic [63:0] phi, plo,
                                output logic [63:0] hi, lo, output logic dz);
    longint sa, sb;
    logic [63:0] ua, ub, mask, p;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    sa = longint'(ua << (64 - w)) >>> (64 - w);
    sb = longint'(ub << (64 - w)) >>> (64 - w);
    dz = 1'b0;
    hi = phi;
    lo = plo;
    case (op)
      2'd0: begin p = 64'(sa * sb); hi = (p >> w) & mask; lo = p & mask; end
      2'd1: begin p = ua * ub;      hi = (p >> w) & mask; lo = p & mask; end
      2'd2: if (sb == 0) dz = 1'b1;
            else begin lo = 64'(sa / sb) & mask; hi = 64'(sa % sb) & mask; end
      default: if (ub == 0) dz = 1'b1;
            else begin lo = ua / ub; hi = ua % ub; end
    endcase
  endfunction

  task automatic exec32(input string name, input logic [1:0] op, input logic [31:0] a, b,
                        input logic [31:0] ehi, elo, input logic edz,
                        input bit chained, input int restart_at);
    int   done_cyc;
    logic dz;
    bit   busy_ok, hold_ok;
    done_cyc = -1; dz = 1'b0; busy_ok = 1'b1; hold_ok = 1'b1;
    if (!chained) @(negedge clk);
    b32.start_i = 1'b1; b32.op_i = op; b32.operand_a_i = a; b32.operand_b_i = b;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (b32.done_o) begin
        done_cyc = c;
        dz = b32.div_zero_o;
        if (b32.busy_o) busy_ok = 1'b0;
        b32.start_i = 1'b0;
`ifdef HILO_WRITE_EN
        b32.hi_write_i = 1'b0; b32.lo_write_i = 1'b0;
`endif
        break;
      end
      if (!b32.busy_o) busy_ok = 1'b0;
      if (b32.hi_o !== mhi[31:0] || b32.lo_o !== mlo[31:0]) hold_ok = 1'b0;
      b32.start_i = (c == restart_at);
      b32.op_i = 2'($urandom); b32.operand_a_i = $urandom; b32.operand_b_i = $urandom;
`ifdef HILO_WRITE_EN
      b32.hi_write_i = 1'($urandom); b32.lo_write_i = 1'($urandom); b32.write_data_i = $urandom;
`endif
    end
    check({name, " done_cycle"}, 64'(done_cyc), edz ? 64'd2 : 64'd35);
    check({name, " busy_window"}, 64'(busy_ok), 64'd1);
    check({name, " hilo_hold"}, 64'(hold_ok), 64'd1);
    check({name, " div_zero"}, 64'(dz), 64'(edz));
    check({name, " hi"}, 64'(b32.hi_o), 64'(ehi));
    check({name, " lo"}, 64'(b32.lo_o), 64'(elo));
    mhi = 64'(ehi);
    mlo = 64'(elo);
  endtask

  task automatic exec8(input string name, input logic [1:0] op, input logic [7:0] a, b,
                       input logic [7:0] ehi, elo);
    int done_cyc;
    done_cyc = -1;
    @(negedge clk);
    b8.start_i = 1'b1; b8.op_i = op; b8.operand_a_i = a; b8.operand_b_i = b;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      b8.start_i = 1'b0;
      if (b8.done_o) begin done_cyc = c; break; end
    end
    check({name, " done_cycle"}, 64'(done_cyc), 64'd11);
    check({name, " hi"}, 64'(b8.hi_o), 64'(ehi));
    check({name, " lo"}, 64'(b8.lo_o), 64'(elo));
  endtask

  logic [1:0]  rop;
  logic [31:0] ra, rb;
  logic [63:0] rhi, rlo;
  logic        rdz;
  int          seen;

  initial begin
    rst = 1'b1;
    b32.start_i = 1'b0; b32.op_i = '0; b32.operand_a_i = '0; b32.operand_b_i = '0;
    b8.start_i  = 1'b0; b8.op_i  = '0; b8.operand_a_i  = '0; b8.operand_b_i  = '0;
`ifdef HILO_WRITE_EN
    b32.hi_write_i = 1'b0; b32.lo_write_i = 1'b0; b32.write_data_i = '0;
    b8.hi_write_i  = 1'b0; b8.lo_write_i  = 1'b0; b8.write_data_i  = '0;
`endif
    repeat (3) @(negedge clk);
    check("reset busy", 64'(b32.busy_o), 64'd0);
    check("reset done", 64'(b32.done_o), 64'd0);
    check("reset div_zero", 64'(b32.div_zero_o), 64'd0);
    check("reset hi", 64'(b32.hi_o), 64'd0);
    check("reset lo", 64'(b32.lo_o), 64'd0);
    check("reset w8 busy", 64'(b8.busy_o), 64'd0);
    rst = 1'b0;

    vecs[0]  = '{2'd1, 32'd11,         32'd3,         32'h0,        32'h21,       1'b0};
    vecs[1]  = '{2'd0, 32'hFFFFFFF9,   32'd6,         32'hFFFFFFFF, 32'hFFFFFFD6, 1'b0};
    vecs[2]  = '{2'd2, 32'hFFFFFFF9,   32'd2,         32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0};
    vecs[3]  = '{2'd2, 32'h80000000,   32'hFFFFFFFF,  32'h0,        32'h80000000, 1'b0};
    vecs[4]  = '{2'd3, 32'd100,        32'd0,         32'h0,        32'h80000000, 1'b1};
    vecs[5]  = '{2'd3, 32'd100,        32'd7,         32'd2,        32'd14,       1'b0};
    vecs[6]  = '{2'd1, 32'hFFFFFFFF,   32'hFFFFFFFF,  32'hFFFFFFFE, 32'h00000001, 1'b0};
    vecs[7]  = '{2'd2, 32'd7,          32'hFFFFFFFE,  32'd1,        32'hFFFFFFFD, 1'b0};
    vecs[8]  = '{2'd0, 32'h80000000,   32'h80000000,  32'h40000000, 32'h0,        1'b0};
    vecs[9]  = '{2'd2, 32'hFFFFFFFB,   32'd0,         32'h40000000, 32'h0,        1'b1};
    vecs[10] = '{2'd2, 32'hFFFFFFF9,   32'hFFFFFFFE,  32'hFFFFFFFF, 32'd3,        1'b0};
    vecs[11] = '{2'd0, 32'd7,          32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFF9, 1'b0};
    for (int i = 0; i < 12; i++)
      exec32($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].hi, vecs[i].lo, vecs[i].dz, 1'b0, 0);

    for (int i = 0; i < 30; i++) begin
      rop = 2'($urandom);
      ra  = ($urandom_range(0, 5) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 5))
        0:       rb = '0;
        1:       rb = 32'hFFFFFFFF;
        2, 3:    rb = 32'($urandom_range(1, 20));
        default: rb = 32'($urandom);
      endcase
      model(32, rop, 64'(ra), 64'(rb), mhi, mlo, rhi, rlo, rdz);
      exec32($sformatf("rand%0d", i), rop, ra, rb, rhi[31:0], rlo[31:0], rdz, 1'b0, 0);
    end

    exec32("restart", 2'd1, 32'h1234, 32'h5678, 32'h0, 32'h06260060, 1'b0, 1'b0, 10);
    seen = 0;
    repeat (40) begin @(negedge clk); if (b32.done_o) seen++; end
    check("restart no_second_done", 64'(seen), 64'd0);

    exec32("chain_a", 2'd1, 32'd9, 32'd9, 32'h0, 32'd81, 1'b0, 1'b0, 0);
    exec32("chain_b", 2'd3, 32'd81, 32'd4, 32'd1, 32'd20, 1'b0, 1'b1, 0);

    exec8("w8 mult", 2'd0, 8'h80, 8'h80, 8'h40, 8'h00);
    exec8("w8 div_min", 2'd2, 8'h80, 8'hFF, 8'h00, 8'h80);
    exec8("w8 multu", 2'd1, 8'hFF, 8'hFF, 8'hFE, 8'h01);
    for (int i = 0; i < 4; i++) begin
      rop = 2'($urandom_range(0, 1)) | 2'($urandom_range(0, 1) << 1);
      ra = 32'($urandom_range(0, 255));
      rb = 32'($urandom_range(1, 255));
      model(8, rop, 64'(ra), 64'(rb), 64'd0, 64'd0, rhi, rlo, rdz);
      exec8($sformatf("w8 rand%0d", i), rop, ra[7:0], rb[7:0], rhi[7:0], rlo[7:0]);
    end

`ifdef HILO_WRITE_EN
    @(negedge clk);
    b32.lo_write_i = 1'b1; b32.write_data_i = 32'h12345678;
    @(negedge clk);
    b32.lo_write_i = 1'b0;
    check("mtlo lo", 64'(b32.lo_o), 64'h12345678);
    b32.hi_write_i = 1'b1; b32.lo_write_i = 1'b1; b32.write_data_i = 32'hAABBCCDD;
    @(negedge clk);
    b32.hi_write_i = 1'b0; b32.lo_write_i = 1'b0;
    check("mthi_mtlo hi", 64'(b32.hi_o), 64'hAABBCCDD);
    check("mthi_mtlo lo", 64'(b32.lo_o), 64'hAABBCCDD);
    mhi = 64'hAABBCCDD; mlo = 64'hAABBCCDD;
    exec32("write_while_busy", 2'd1, 32'd2, 32'd3, 32'h0, 32'd6, 1'b0, 1'b0, 0);
    @(negedge clk);
    b32.start_i = 1'b1; b32.op_i = 2'd1; b32.operand_a_i = 32'd4; b32.operand_b_i = 32'd5;
    b32.hi_write_i = 1'b1; b32.write_data_i = 32'h0BADF00D;
    @(negedge clk);
    b32.start_i = 1'b0; b32.hi_write_i = 1'b0;
    check("write_with_start busy", 64'(b32.busy_o), 64'd1);
    check("write_with_start hi", 64'(b32.hi_o), 64'h0BADF00D);
    seen = 0;
    for (int c = 2; c <= 60; c++) begin
      @(negedge clk);
      if (b32.done_o) begin seen = c; break; end
    end
    check("write_with_start done_cycle", 64'(seen), 64'd35);
    check("write_with_start lo", 64'(b32.lo_o), 64'd20);
    check("write_with_start hi_final", 64'(b32.hi_o), 64'd0);
    mhi = 64'd0; mlo = 64'd20;
`endif

    exec32("pre_reset", 2'd1, 32'd5, 32'd7, 32'h0, 32'd35, 1'b0, 1'b0, 0);
    @(negedge clk);
    b32.start_i = 1'b1; b32.op_i = 2'd3; b32.operand_a_i = 32'd1000; b32.operand_b_i = 32'd7;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      b32.start_i = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    check("abort busy", 64'(b32.busy_o), 64'd0);
    check("abort done", 64'(b32.done_o), 64'd0);
    check("abort hi", 64'(b32.hi_o), 64'd0);
    check("abort lo", 64'(b32.lo_o), 64'd0);
    rst = 1'b0;
    seen = 0;
    repeat (60) begin @(negedge clk); if (b32.done_o) seen++; end
    check("abort no_done", 64'(seen), 64'd0);
    mhi = 64'd0; mlo = 64'd0;
    exec32("post_reset", 2'd3, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0, 1'b0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
